// File: rtl/rs_issue_unit.sv
// rtl/rs_issue_unit.sv - round-robin issue from the ALU reservation station into a 2-stage execute pipe
module rs_issue_unit #(
  parameter int RS_SIZE = 15,
  parameter int TAG_W   = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [RS_SIZE-1:0]       rs_ready,
  input  logic [RS_SIZE*WIDTH-1:0] rs_r1,
  input  logic [RS_SIZE*WIDTH-1:0] rs_r2,
  input  logic [RS_SIZE*TAG_W-1:0] rs_tag,
  input  logic [RS_SIZE*3-1:0]     rs_alu_op,
  input  logic [RS_SIZE*3-1:0]     rs_cmp_op,
  input  logic [RS_SIZE-1:0]       rs_acu,
  input  logic [RS_SIZE-1:0]       rs_f7b5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [WIDTH-1:0]         out_data,
  output logic [RS_SIZE-1:0]       rs_done
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [WIDTH-1:0] r1_arr   [RS_SIZE];
  logic [WIDTH-1:0] r2_arr   [RS_SIZE];
  logic [TAG_W-1:0] tag_arr  [RS_SIZE];
  logic [2:0]       aop_arr  [RS_SIZE];
  logic [2:0]       cop_arr  [RS_SIZE];

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_unpack
    assign r1_arr[g]  = rs_r1[g*WIDTH +: WIDTH];
    assign r2_arr[g]  = rs_r2[g*WIDTH +: WIDTH];
    assign tag_arr[g] = rs_tag[g*TAG_W +: TAG_W];
    assign aop_arr[g] = rs_alu_op[g*3 +: 3];
    assign cop_arr[g] = rs_cmp_op[g*3 +: 3];
  end

  logic [RS_SIZE-1:0] inflight_q, inflight_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_r1_q, s1_r2_q;
  logic [TAG_W-1:0]   s1_tag_q;
  logic [2:0]         s1_aop_q, s1_cop_q;
  logic               s1_acu_q, s1_f7b5_q;
  logic [IDX_W-1:0]   s1_idx_q;

  logic               s2_valid_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic [WIDTH-1:0]   s2_data_q;
  logic [IDX_W-1:0]   s2_idx_q;

  logic [RS_SIZE-1:0] eligible;
  logic               grant_found;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;
  logic               stall, issue, xfer;

  assign eligible = rs_ready & ~inflight_q;
  assign stall    = s2_valid_q & ~out_ready;
  assign xfer     = s2_valid_q & out_ready;
  assign issue    = grant_found & ~stall & ~flush;

  // Scan from the pointer upward, wrapping at RS_SIZE rather than at a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < RS_SIZE; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(RS_SIZE)) begin
        cand_sum = cand_sum - (IDX_W+1)'(RS_SIZE);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_idx == IDX_W'(RS_SIZE-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // A retiring entry stays masked until the edge, so it cannot be re-granted the same cycle.
  always_comb begin
    inflight_d = inflight_q;
    if (xfer) inflight_d = inflight_d & ~(RS_SIZE'(1) << s2_idx_q);
    if (issue) inflight_d = inflight_d | (RS_SIZE'(1) << grant_idx);
  end

  assign rs_done = (xfer && !flush) ? (RS_SIZE'(1) << s2_idx_q) : '0;

  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res, exec_res;
  logic             cmp_bit;

  assign shamt = s1_r2_q[4:0];

  always_comb begin
    alu_res = '0;
    case (s1_aop_q)
      3'b000: alu_res = s1_f7b5_q ? (s1_r1_q - s1_r2_q) : (s1_r1_q + s1_r2_q);
      3'b001: alu_res = s1_r1_q << shamt;
      3'b010: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_r1_q) < $signed(s1_r2_q))};
      3'b011: alu_res = {{(WIDTH-1){1'b0}}, (s1_r1_q < s1_r2_q)};
      3'b100: alu_res = s1_r1_q ^ s1_r2_q;
      3'b101: alu_res = s1_f7b5_q ? $unsigned($signed(s1_r1_q) >>> shamt) : (s1_r1_q >> shamt);
      3'b110: alu_res = s1_r1_q | s1_r2_q;
      default: alu_res = s1_r1_q & s1_r2_q;
    endcase
    cmp_bit = 1'b0;
    case (s1_cop_q)
      3'b000: cmp_bit = (s1_r1_q == s1_r2_q);
      3'b001: cmp_bit = (s1_r1_q != s1_r2_q);
      3'b100: cmp_bit = ($signed(s1_r1_q) < $signed(s1_r2_q));
      3'b101: cmp_bit = ($signed(s1_r1_q) >= $signed(s1_r2_q));
      3'b110: cmp_bit = (s1_r1_q < s1_r2_q);
      3'b111: cmp_bit = (s1_r1_q >= s1_r2_q);
      default: cmp_bit = 1'b0;
    endcase
    exec_res = s1_acu_q ? {{(WIDTH-1){1'b0}}, cmp_bit} : alu_res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q <= '0;
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_r1_q    <= '0;
      s1_r2_q    <= '0;
      s1_tag_q   <= '0;
      s1_aop_q   <= '0;
      s1_cop_q   <= '0;
      s1_acu_q   <= 1'b0;
      s1_f7b5_q  <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_data_q  <= '0;
      s2_idx_q   <= '0;
    end else if (flush) begin
      inflight_q <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
      if (!stall) begin
        s1_valid_q <= issue;
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_tag_q  <= s1_tag_q;
          s2_data_q <= exec_res;
          s2_idx_q  <= s1_idx_q;
        end
      end
      if (issue) begin
        s1_r1_q   <= r1_arr[grant_idx];
        s1_r2_q   <= r2_arr[grant_idx];
        s1_tag_q  <= tag_arr[grant_idx];
        s1_aop_q  <= aop_arr[grant_idx];
        s1_cop_q  <= cop_arr[grant_idx];
        s1_acu_q  <= rs_acu[grant_idx];
        s1_f7b5_q <= rs_f7b5[grant_idx];
        s1_idx_q  <= grant_idx;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_tag   = s2_tag_q;
  assign out_data  = s2_data_q;

endmodule

// File: tb/tb_rs_issue_unit.sv
// tb/tb_rs_issue_unit.sv - directed vector table plus round-robin, stall and flush sequences
module tb_rs_issue_unit;
  localparam int RS = 15;
  localparam int TW = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [RS-1:0]   rs_ready;
  logic [RS*W-1:0] rs_r1, rs_r2;
  logic [RS*TW-1:0] rs_tag;
  logic [RS*3-1:0] rs_alu_op, rs_cmp_op;
  logic [RS-1:0]   rs_acu, rs_f7b5;
  logic            out_valid, out_ready;
  logic [TW-1:0]   out_tag;
  logic [W-1:0]    out_data;
  logic [RS-1:0]   rs_done;

  rs_issue_unit #(.RS_SIZE(RS), .TAG_W(TW), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rs_ready(rs_ready), .rs_r1(rs_r1), .rs_r2(rs_r2), .rs_tag(rs_tag),
    .rs_alu_op(rs_alu_op), .rs_cmp_op(rs_cmp_op), .rs_acu(rs_acu), .rs_f7b5(rs_f7b5),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_data(out_data), .rs_done(rs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        acu;
    logic [2:0]  aop;
    logic [2:0]  cop;
    logic        f7;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic acu, input logic [2:0] aop,
                           input logic [2:0] cop, input logic f7, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [3:0] tag);
    rs_r1[idx*W +: W]     = r1;
    rs_r2[idx*W +: W]     = r2;
    rs_tag[idx*TW +: TW]  = tag;
    rs_alu_op[idx*3 +: 3] = aop;
    rs_cmp_op[idx*3 +: 3] = cop;
    rs_acu[idx]           = acu;
    rs_f7b5[idx]          = f7;
  endtask

  int rr_exp [6];

  initial begin
    vecs[0]  = '{3,  1'b0, 3'b000, 3'b000, 1'b0, 32'd5,        32'd7,     4'd9,  32'd12};
    vecs[1]  = '{0,  1'b0, 3'b000, 3'b000, 1'b1, 32'd3,        32'd5,     4'd1,  32'hFFFFFFFE};
    vecs[2]  = '{2,  1'b0, 3'b101, 3'b000, 1'b0, 32'h80000000, 32'd4,     4'd2,  32'h08000000};
    vecs[3]  = '{4,  1'b0, 3'b001, 3'b000, 1'b0, 32'd1,        32'h23,    4'd4,  32'd8};
    vecs[4]  = '{5,  1'b0, 3'b100, 3'b000, 1'b0, 32'hF0F0,     32'hFF00,  4'd5,  32'h0FF0};
    vecs[5]  = '{6,  1'b0, 3'b110, 3'b000, 1'b0, 32'hF0F0,     32'hFF00,  4'd6,  32'hFFF0};
    vecs[6]  = '{7,  1'b0, 3'b111, 3'b000, 1'b0, 32'hF0F0,     32'hFF00,  4'd7,  32'hF000};
    vecs[7]  = '{8,  1'b1, 3'b000, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1,     4'd8,  32'd1};
    vecs[8]  = '{9,  1'b1, 3'b000, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1,     4'd9,  32'd0};
    vecs[9]  = '{10, 1'b1, 3'b000, 3'b000, 1'b0, 32'd7,        32'd7,     4'd10, 32'd1};
    vecs[10] = '{11, 1'b1, 3'b000, 3'b001, 1'b0, 32'd7,        32'd7,     4'd11, 32'd0};
    vecs[11] = '{12, 1'b1, 3'b000, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1,     4'd12, 32'd0};
    vecs[12] = '{14, 1'b1, 3'b000, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1,     4'd14, 32'd1};
    vecs[13] = '{1,  1'b0, 3'b101, 3'b000, 1'b1, 32'h80000000, 32'd4,     4'd15, 32'hF8000000};

    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; rs_ready = '0;
    rs_r1 = '0; rs_r2 = '0; rs_tag = '0; rs_alu_op = '0; rs_cmp_op = '0;
    rs_acu = '0; rs_f7b5 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_tag",   32'(out_tag),   32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_done",  32'(rs_done),   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single-entry vectors: grant at the next edge, result two edges later.
    for (int i = 0; i < 14; i++) begin
      set_entry(vecs[i].idx, vecs[i].acu, vecs[i].aop, vecs[i].cop, vecs[i].f7,
                vecs[i].r1, vecs[i].r2, vecs[i].tag);
      rs_ready = RS'(1) << vecs[i].idx;
      @(negedge clk);
      rs_ready = '0;
      chk($sformatf("v%0d_lat1", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
      chk($sformatf("v%0d_done", i), 32'(rs_done), 32'd1 << vecs[i].idx);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_done0", i), 32'(rs_done), 32'd0);
    end

    // Round robin on entries 0 and 2, pointer left at 2 by the last vector.
    set_entry(0, 1'b0, 3'b000, 3'b000, 1'b0, 32'd10, 32'd1, 4'hA);
    set_entry(2, 1'b0, 3'b000, 3'b000, 1'b0, 32'd20, 32'd2, 4'hC);
    rr_exp = '{2, 0, -1, 2, 0, -1};
    rs_ready = 15'h0005;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_valid", c), 32'(out_valid), (rr_exp[c] >= 0) ? 32'd1 : 32'd0);
      if (rr_exp[c] >= 0) begin
        chk($sformatf("rr%0d_tag", c), 32'(out_tag), (rr_exp[c] == 2) ? 32'hC : 32'hA);
        chk($sformatf("rr%0d_data", c), out_data, (rr_exp[c] == 2) ? 32'd22 : 32'd11);
        chk($sformatf("rr%0d_done", c), 32'(rs_done), 32'd1 << rr_exp[c]);
      end else begin
        chk($sformatf("rr%0d_done", c), 32'(rs_done), 32'd0);
      end
    end
    rs_ready = '0;
    repeat (4) @(negedge clk);
    chk("rr_drain", 32'(out_valid), 32'd0);

    // Stall: entry 3 held in S2 for three cycles, entry 4 must wait.
    set_entry(3, 1'b0, 3'b000, 3'b000, 1'b0, 32'd5, 32'd7, 4'd9);
    set_entry(4, 1'b0, 3'b000, 3'b000, 1'b0, 32'd1, 32'd1, 4'd4);
    out_ready = 1'b0;
    rs_ready = 15'h0008;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) rs_ready = 15'h0018;
      chk($sformatf("st%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("st%0d_data", c), out_data, 32'd12);
      chk($sformatf("st%0d_tag", c), 32'(out_tag), 32'd9);
      chk($sformatf("st%0d_done", c), 32'(rs_done), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("st_release_done", 32'(rs_done), 32'h8);
    @(negedge clk);
    rs_ready = '0;
    chk("st_no_grant", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("st_e4_valid", 32'(out_valid), 32'd1);
    chk("st_e4_tag", 32'(out_tag), 32'd4);
    chk("st_e4_data", out_data, 32'd2);
    chk("st_e4_done", 32'(rs_done), 32'h10);
    @(negedge clk);
    chk("st_idle", 32'(out_valid), 32'd0);

    // Flush with S1 and S2 both occupied and the sink ready.
    set_entry(5, 1'b0, 3'b000, 3'b000, 1'b0, 32'd100, 32'd5, 4'd5);
    set_entry(6, 1'b0, 3'b000, 3'b000, 1'b0, 32'd200, 32'd6, 4'd6);
    rs_ready = 15'h0060;
    @(negedge clk);
    @(negedge clk);
    chk("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_done", 32'(rs_done), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_done_after", 32'(rs_done), 32'd0);
    @(negedge clk);
    chk("fl_s1_only", 32'(out_valid), 32'd0);
    @(negedge clk);
    rs_ready = '0;
    chk("fl_re5_valid", 32'(out_valid), 32'd1);
    chk("fl_re5_tag", 32'(out_tag), 32'd5);
    chk("fl_re5_data", out_data, 32'd105);
    chk("fl_re5_done", 32'(rs_done), 32'h20);
    @(negedge clk);
    chk("fl_re6_valid", 32'(out_valid), 32'd1);
    chk("fl_re6_tag", 32'(out_tag), 32'd6);
    chk("fl_re6_data", out_data, 32'd206);
    chk("fl_re6_done", 32'(rs_done), 32'h40);
    @(negedge clk);
    chk("fl_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
